ahb_apb_bridge: RTL and testbench
=================================

AHB_APB_BRIDGE -- requirements
Module: ahb_apb_bridge

Interface
REQ-001 Parameter: ADDR_W, 32, AHB/APB address width.
REQ-002 Parameter: DATA_W, 32, AHB/APB data width.
REQ-003 HCLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 HRESETn  in  1  reset; synchronous, active-high (asserted = 1).
REQ-005 HSEL  in  1  bridge select from the AHB address decoder.
REQ-006 HADDR  in  ADDR_W  AHB address; HTRANS  in  2  transfer type; HWRITE  in  1  direction.
REQ-007 HWDATA  in  DATA_W  write data, valid in the data phase; HREADY  in  1  bus-wide ready.
REQ-008 HRDATA  out  DATA_W  read data; HREADYOUT  out  1  bridge ready; HRESP  out  1  0=OKAY, 1=ERROR.
REQ-009 PADDR  out  ADDR_W; PWRITE  out  1; PWDATA  out  DATA_W; PENABLE  out  1.
REQ-010 PSEL  out  4  one-hot APB peripheral select.
REQ-011 PRDATA  in  DATA_W; PREADY  in  1; PSLVERR  in  1.

Function
REQ-012 States: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2; all outputs registered.
REQ-013 Transfer accept: state IDLE or ERR2, HREADY=1, HSEL=1 and HTRANS in {10,11}; HADDR and HWRITE are latched.
REQ-014 HTRANS 00/01, HSEL=0 or HREADY=0 in IDLE: no accept, HREADYOUT=1, HRESP=0, no APB activity.
REQ-015 Accepted read -> SETUP next cycle; accepted write -> WDATA next cycle.
REQ-016 WDATA (one cycle, HREADYOUT=0): PWDATA latched from HWDATA -> SETUP.
REQ-017 SETUP (one cycle): PSEL one-hot of latched HADDR[4:3] (00->0001 ... 11->1000), PENABLE=0, PADDR/PWRITE driven from latch, HREADYOUT=0 -> ACCESS.
REQ-018 ACCESS: PSEL and PENABLE=1, PADDR/PWRITE/PWDATA held; HREADYOUT=0 while PREADY=0, unbounded wait.
REQ-019 ACCESS, PREADY=1, PSLVERR=0: HRDATA latches PRDATA on reads; PSEL, PENABLE -> 0; HREADYOUT=1, HRESP=0 next cycle -> IDLE.
REQ-020 ACCESS, PREADY=1, PSLVERR=1 -> ERR1: HREADYOUT=0, HRESP=1; then ERR2: HREADYOUT=1, HRESP=1; then IDLE unless a new transfer is accepted in ERR2 (REQ-013).
REQ-021 Latency: read completes (HREADYOUT=1) 3 cycles after the address phase with PREADY=1 on first ACCESS; write completes in 4.
REQ-022 HRDATA holds its last value outside reads; PWDATA holds between writes.
REQ-023 PSEL and PENABLE are never asserted in IDLE, WDATA, ERR1 or ERR2; PSEL has at most one bit set.

Reset
REQ-024 HRESETn=1 at a clock edge forces state IDLE, HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0 and HRDATA=0, abandoning any transfer in progress, including one in ACCESS.
REQ-025 No transfer is accepted in a cycle with HRESETn=1.

Structure
REQ-026 Shared package ahb_apb_pkg holds HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HRESP codes, the state encoding and the slot-select bit range [4:3].
REQ-027 One combinational sub-module, apb_psel_decode, maps the 2-bit slot to the 4-bit one-hot PSEL.

Verification
REQ-028 Read HADDR=0x08, PREADY=1, PRDATA=0xDEADBEEF -> PSEL=0010 in SETUP/ACCESS; HRDATA=0xDEADBEEF with HREADYOUT=1 three cycles after the address phase.
REQ-029 Write HADDR=0x18, HWDATA=0x12345678 -> PSEL=1000, PWRITE=1, PWDATA=0x12345678 stable across SETUP/ACCESS; OKAY after 4 cycles.
REQ-030 Read with PREADY low for 3 ACCESS cycles -> PENABLE held 4 cycles, HREADYOUT=0 throughout, completes on the cycle after PREADY=1.
REQ-031 Write with PSLVERR=1 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); a NONSEQ read in ERR2 is accepted -> SETUP next cycle.
REQ-032 HRESETn=1 during ACCESS -> next edge all outputs at REQ-024 values; HTRANS=BUSY with HSEL=1 afterwards -> no APB activity, OKAY.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared definitions for the AHB-to-APB bridge: bus encodings, FSM states
// and the address bits that pick one of the four APB peripheral slots.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Address bits that select the APB peripheral slot
    localparam int SLOT_MSB = 4;
    localparam int SLOT_LSB = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_e;

endpackage

// File: rtl/apb_psel_decode.sv
// Maps the 2-bit peripheral slot number to a one-hot 4-bit APB select.
module apb_psel_decode (
    input  logic [1:0] slot,
    output logic [3:0] psel
);

    // Shift a single set bit into the slot position
    always_comb begin
        psel = 4'b0001 << slot;
    end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge. One transfer at a time; the AHB side
// is stalled with HREADYOUT=0 until the APB access finishes. Slave errors
// are returned as the two-cycle AHB ERROR response. All outputs are flops.
module ahb_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PENABLE,
    output logic [3:0]        PSEL,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    state_e            state_q, state_d;
    logic              hreadyout_q, hreadyout_d;
    logic              hresp_q, hresp_d;
    logic [3:0]        psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;

    logic              accept;
    logic [1:0]        slot_sel;
    logic [3:0]        psel_dec;

    // A new transfer can only start when the bridge is free (IDLE or the
    // second ERROR cycle) and the AHB bus presents a real transfer to us
    always_comb begin
        accept = (state_q == ST_IDLE || state_q == ST_ERR2) && HREADY && HSEL &&
                 (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    end

    // A read goes straight to SETUP from the address phase, so decode the
    // live address then; otherwise decode the latched address
    always_comb begin
        slot_sel = accept ? HADDR[SLOT_MSB:SLOT_LSB] : paddr_q[SLOT_MSB:SLOT_LSB];
    end

    apb_psel_decode u_psel_decode (
        .slot (slot_sel),
        .psel (psel_dec)
    );

    // Next-state and next-output computation for the bridge FSM
    always_comb begin
        state_d     = state_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        hrdata_d    = hrdata_q;
        unique case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept) begin
                    paddr_d     = HADDR;
                    pwrite_d    = HWRITE;
                    hreadyout_d = 1'b0;
                    hresp_d     = HRESP_OKAY;
                    if (HWRITE) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_SETUP;
                        psel_d  = psel_dec;
                    end
                end else begin
                    state_d     = ST_IDLE;
                    hreadyout_d = 1'b1;
                    hresp_d     = HRESP_OKAY;
                end
            end
            ST_WDATA: begin
                pwdata_d = HWDATA;
                psel_d   = psel_dec;
                state_d  = ST_SETUP;
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    psel_d    = 4'b0000;
                    penable_d = 1'b0;
                    if (PSLVERR) begin
                        state_d = ST_ERR1;
                        hresp_d = HRESP_ERROR;
                    end else begin
                        state_d     = ST_IDLE;
                        hreadyout_d = 1'b1;
                        hresp_d     = HRESP_OKAY;
                        if (!pwrite_q) begin
                            hrdata_d = PRDATA;
                        end
                    end
                end
            end
            ST_ERR1: begin
                state_d     = ST_ERR2;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_ERROR;
            end
            default: begin
                state_d     = ST_IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
                psel_d      = 4'b0000;
                penable_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer in flight
    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            psel_q      <= 4'b0000;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            hrdata_q    <= hrdata_d;
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PENABLE   = penable_q;
    assign PSEL      = psel_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed testbench for ahb_apb_bridge: reads, writes, wait states,
// slave error with back-to-back transfer, and reset during an APB access.
module tb_ahb_apb_bridge;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PENABLE;
    logic [3:0]  PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int check_count = 0;
    int error_count = 0;

    ahb_apb_bridge #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PENABLE   (PENABLE),
        .PSEL      (PSEL),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    // 100 MHz clock
    always #5 HCLK = ~HCLK;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Drive the AHB address-phase controls and write data
    task automatic applyStimulus(input logic sel, input logic [1:0] trans,
                                 input logic write, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = write;
        HADDR  = addr;
        HWDATA = wdata;
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Check that every output holds its reset value
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_hreadyout"}, 32'(HREADYOUT), 32'd1);
        checkOutput({tag, "_hresp"},     32'(HRESP),     32'd0);
        checkOutput({tag, "_psel"},      32'(PSEL),      32'd0);
        checkOutput({tag, "_penable"},   32'(PENABLE),   32'd0);
        checkOutput({tag, "_pwrite"},    32'(PWRITE),    32'd0);
        checkOutput({tag, "_paddr"},     PADDR,          32'd0);
        checkOutput({tag, "_pwdata"},    PWDATA,         32'd0);
        checkOutput({tag, "_hrdata"},    HRDATA,         32'd0);
    endtask

    // Directed test sequence
    initial begin
        HRESETn = 1'b1;
        HREADY  = 1'b1;
        PRDATA  = 32'h0;
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        $display("[TB] reset values");
        checkResetValues("rst");
        HRESETn = 1'b0;
        tick();

        $display("[TB] read 0x08");
        PRDATA = 32'hDEADBEEF;
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h08, 32'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        checkOutput("rd_setup_psel",    32'(PSEL),      32'h2);
        checkOutput("rd_setup_penable", 32'(PENABLE),   32'd0);
        checkOutput("rd_setup_hready",  32'(HREADYOUT), 32'd0);
        checkOutput("rd_setup_paddr",   PADDR,          32'h08);
        checkOutput("rd_setup_pwrite",  32'(PWRITE),    32'd0);
        tick();
        checkOutput("rd_access_psel",    32'(PSEL),      32'h2);
        checkOutput("rd_access_penable", 32'(PENABLE),   32'd1);
        checkOutput("rd_access_hready",  32'(HREADYOUT), 32'd0);
        tick();
        checkOutput("rd_done_hready",  32'(HREADYOUT), 32'd1);
        checkOutput("rd_done_hresp",   32'(HRESP),     32'd0);
        checkOutput("rd_done_hrdata",  HRDATA,         32'hDEADBEEF);
        checkOutput("rd_done_psel",    32'(PSEL),      32'd0);
        checkOutput("rd_done_penable", 32'(PENABLE),   32'd0);

        $display("[TB] write 0x18");
        applyStimulus(1'b1, 2'b10, 1'b1, 32'h18, 32'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h12345678);
        checkOutput("wr_wdata_hready", 32'(HREADYOUT), 32'd0);
        checkOutput("wr_wdata_psel",   32'(PSEL),      32'd0);
        tick();
        HWDATA = 32'hFFFFFFFF;
        checkOutput("wr_setup_psel",    32'(PSEL),    32'h8);
        checkOutput("wr_setup_pwrite",  32'(PWRITE),  32'd1);
        checkOutput("wr_setup_pwdata",  PWDATA,       32'h12345678);
        checkOutput("wr_setup_penable", 32'(PENABLE), 32'd0);
        checkOutput("wr_setup_paddr",   PADDR,        32'h18);
        tick();
        checkOutput("wr_access_psel",    32'(PSEL),      32'h8);
        checkOutput("wr_access_penable", 32'(PENABLE),   32'd1);
        checkOutput("wr_access_pwdata",  PWDATA,         32'h12345678);
        checkOutput("wr_access_hready",  32'(HREADYOUT), 32'd0);
        tick();
        checkOutput("wr_done_hready", 32'(HREADYOUT), 32'd1);
        checkOutput("wr_done_hresp",  32'(HRESP),     32'd0);
        checkOutput("wr_done_hrdata", HRDATA,         32'hDEADBEEF);
        checkOutput("wr_done_pwdata", PWDATA,         32'h12345678);

        $display("[TB] read 0x00 with wait states");
        PRDATA = 32'hCAFEF00D;
        PREADY = 1'b0;
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h00, 32'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        checkOutput("wait_setup_psel", 32'(PSEL), 32'h1);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("wait_penable_%0d", i), 32'(PENABLE),   32'd1);
            checkOutput($sformatf("wait_hready_%0d", i),  32'(HREADYOUT), 32'd0);
            if (i == 3) PREADY = 1'b1;
            tick();
        end
        checkOutput("wait_done_hready",  32'(HREADYOUT), 32'd1);
        checkOutput("wait_done_hrdata",  HRDATA,         32'hCAFEF00D);
        checkOutput("wait_done_penable", 32'(PENABLE),   32'd0);

        $display("[TB] write 0x10 with slave error");
        applyStimulus(1'b1, 2'b10, 1'b1, 32'h10, 32'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'hA5A5A5A5);
        tick();
        checkOutput("err_setup_psel", 32'(PSEL), 32'h4);
        PSLVERR = 1'b1;
        tick();
        tick();
        PSLVERR = 1'b0;
        checkOutput("err1_hready",  32'(HREADYOUT), 32'd0);
        checkOutput("err1_hresp",   32'(HRESP),     32'd1);
        checkOutput("err1_psel",    32'(PSEL),      32'd0);
        checkOutput("err1_penable", 32'(PENABLE),   32'd0);
        tick();
        checkOutput("err2_hready", 32'(HREADYOUT), 32'd1);
        checkOutput("err2_hresp",  32'(HRESP),     32'd1);
        PRDATA = 32'h0BADF00D;
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h08, 32'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        checkOutput("b2b_setup_psel",    32'(PSEL),      32'h2);
        checkOutput("b2b_setup_hready",  32'(HREADYOUT), 32'd0);
        checkOutput("b2b_setup_hresp",   32'(HRESP),     32'd0);
        checkOutput("b2b_setup_penable", 32'(PENABLE),   32'd0);
        tick();
        tick();
        checkOutput("b2b_done_hready", 32'(HREADYOUT), 32'd1);
        checkOutput("b2b_done_hrdata", HRDATA,         32'h0BADF00D);
        checkOutput("b2b_done_pwdata", PWDATA,         32'hA5A5A5A5);

        $display("[TB] reset during ACCESS");
        PREADY = 1'b0;
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h18, 32'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("rstacc_penable", 32'(PENABLE), 32'd1);
        HRESETn = 1'b1;
        tick();
        checkResetValues("rstacc");

        $display("[TB] no accept while reset asserted");
        PREADY = 1'b1;
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h08, 32'h0);
        tick();
        HRESETn = 1'b0;
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h08, 32'h0);
        tick();
        checkOutput("rstacc_noacc_psel",   32'(PSEL),      32'd0);
        checkOutput("rstacc_noacc_hready", 32'(HREADYOUT), 32'd1);

        $display("[TB] BUSY, unselected and HREADY low are ignored");
        tick();
        checkOutput("busy_psel",    32'(PSEL),      32'd0);
        checkOutput("busy_penable", 32'(PENABLE),   32'd0);
        checkOutput("busy_hready",  32'(HREADYOUT), 32'd1);
        checkOutput("busy_hresp",   32'(HRESP),     32'd0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
        tick();
        tick();
        checkOutput("nosel_psel",   32'(PSEL),      32'd0);
        checkOutput("nosel_hready", 32'(HREADYOUT), 32'd1);
        HREADY = 1'b0;
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h08, 32'h0);
        tick();
        tick();
        checkOutput("nohready_psel",   32'(PSEL),      32'd0);
        checkOutput("nohready_hready", 32'(HREADYOUT), 32'd1);
        HREADY = 1'b1;
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
